lpddr2_avalon_bridge: RTL

Bridges the CPU-side LPDDR2 request ports (word address, write data, level read/write requests) onto the Avalon-MM local interface of the LPDDR2 hard controller. It sits directly downstream of the CPU top level, on the memory clock domain. It serialises one single-word transaction at a time, waits for controller calibration, and bounds every access with a timeout so a hung controller cannot stall the CPU forever.

---
 rtl/lpddr2_bridge_pkg.sv | 20 ++
 rtl/lpddr2_avalon_bridge_if.sv | 28 ++
 rtl/bridge_timeout.sv | 38 +++
 rtl/lpddr2_avalon_bridge.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/lpddr2_bridge_pkg.sv
// Shared types and constants for the LPDDR2 CPU-to-Avalon bridge.
package lpddr2_bridge_pkg;

  localparam int DEFAULT_ADDR_W  = 27;
  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_TIMEOUT = 1023;

  localparam logic [31:0] READ_ABORT_DATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD_CMD  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_WR_CMD  = 3'd4,
    ST_DONE    = 3'd5,
    ST_HOLD    = 3'd6
  } bridge_state_t;

endpackage

// File: rtl/lpddr2_avalon_bridge_if.sv
// Avalon-MM local interface of the LPDDR2 hard controller, plus its calibration flag.
interface lpddr2_avalon_bridge_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avl_address;
  logic [DATA_W-1:0]   avl_writedata;
  logic [DATA_W/8-1:0] avl_byteenable;
  logic                avl_burstcount;
  logic                avl_read;
  logic                avl_write;
  logic                avl_waitrequest;
  logic [DATA_W-1:0]   avl_readdata;
  logic                avl_readdatavalid;
  logic                cal_done;

  modport master (
    output avl_address, avl_writedata, avl_byteenable, avl_burstcount,
           avl_read, avl_write,
    input  avl_waitrequest, avl_readdata, avl_readdatavalid, cal_done
  );

  modport slave (
    input  avl_address, avl_writedata, avl_byteenable, avl_burstcount,
           avl_read, avl_write,
    output avl_waitrequest, avl_readdata, avl_readdatavalid, cal_done
  );
endinterface

// File: rtl/bridge_timeout.sv
// Saturating cycle counter that flags when a transaction has been outstanding TIMEOUT cycles.
module bridge_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // Next count: clear wins, otherwise count up and stick at the limit.
  always_comb begin
    count_nxt_s = count_r;
    if (clear) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (enable && (count_r != CNT_W'(TIMEOUT))) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Counter state and registered expiry flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
      expired <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      expired <= (count_nxt_s == CNT_W'(TIMEOUT));
    end
  end
endmodule

// File: rtl/lpddr2_avalon_bridge.sv
// Serialises single-word CPU read/write requests onto the LPDDR2 controller's Avalon-MM port,
// gated by calibration and bounded by a per-transaction timeout.
module lpddr2_avalon_bridge
  import lpddr2_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lpddr2_address,
  input  logic [DATA_W-1:0] lpddr2_write_data,
  input  logic              lpddr2_rreq,
  input  logic              lpddr2_wreq,
  output logic [DATA_W-1:0] lpddr2_read_data,
  output logic              ack,
  output logic              busy,
  output logic              err,
  lpddr2_avalon_bridge_if.master avl
);

  bridge_state_t state_r;
  logic          tmo_enable_s;
  logic          tmo_clear_s;
  logic          tmo_expired_s;

  assign avl.avl_byteenable = {(DATA_W/8){1'b1}};
  assign avl.avl_burstcount = 1'b1;

  assign tmo_enable_s = (state_r == ST_RD_CMD) || (state_r == ST_RD_WAIT) ||
                        (state_r == ST_WR_CMD);
  assign tmo_clear_s  = !tmo_enable_s;

  bridge_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear_s),
    .enable  (tmo_enable_s),
    .expired (tmo_expired_s)
  );

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= ST_INIT;
      lpddr2_read_data  <= {DATA_W{1'b0}};
      ack               <= 1'b0;
      busy              <= 1'b1;
      err               <= 1'b0;
      avl.avl_read      <= 1'b0;
      avl.avl_write     <= 1'b0;
      avl.avl_address   <= {ADDR_W{1'b0}};
      avl.avl_writedata <= {DATA_W{1'b0}};
    end else begin
      ack <= 1'b0;
      case (state_r)
        ST_INIT: begin
          avl.avl_read  <= 1'b0;
          avl.avl_write <= 1'b0;
          if (avl.cal_done) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (!avl.cal_done) begin
            state_r <= ST_INIT;
            busy    <= 1'b1;
          end else if (lpddr2_wreq) begin
            // A write wins a simultaneous request; the collision is still flagged.
            avl.avl_address   <= lpddr2_address;
            avl.avl_writedata <= lpddr2_write_data;
            avl.avl_write     <= 1'b1;
            state_r           <= ST_WR_CMD;
            busy              <= 1'b1;
            if (lpddr2_rreq) begin
              err <= 1'b1;
            end else begin
              err <= err;
            end
          end else if (lpddr2_rreq) begin
            avl.avl_address <= lpddr2_address;
            avl.avl_read    <= 1'b1;
            state_r         <= ST_RD_CMD;
            busy            <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RD_CMD: begin
          if (!avl.avl_waitrequest) begin
            avl.avl_read <= 1'b0;
            state_r      <= ST_RD_WAIT;
          end else if (tmo_expired_s) begin
            avl.avl_read     <= 1'b0;
            err              <= 1'b1;
            lpddr2_read_data <= DATA_W'(READ_ABORT_DATA);
            ack              <= 1'b1;
            state_r          <= ST_DONE;
          end else begin
            avl.avl_read <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (avl.avl_readdatavalid) begin
            lpddr2_read_data <= avl.avl_readdata;
            ack              <= 1'b1;
            state_r          <= ST_DONE;
          end else if (tmo_expired_s) begin
            err              <= 1'b1;
            lpddr2_read_data <= DATA_W'(READ_ABORT_DATA);
            ack              <= 1'b1;
            state_r          <= ST_DONE;
          end else begin
            state_r <= ST_RD_WAIT;
          end
        end
        ST_WR_CMD: begin
          if (!avl.avl_waitrequest) begin
            avl.avl_write <= 1'b0;
            ack           <= 1'b1;
            state_r       <= ST_DONE;
          end else if (tmo_expired_s) begin
            avl.avl_write <= 1'b0;
            err           <= 1'b1;
            ack           <= 1'b1;
            state_r       <= ST_DONE;
          end else begin
            avl.avl_write <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_HOLD;
        end
        ST_HOLD: begin
          // Wait for the level requests to drop so a held request is not re-issued.
          if (!avl.cal_done) begin
            state_r <= ST_INIT;
          end else if (!lpddr2_rreq && !lpddr2_wreq) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r       <= ST_INIT;
          busy          <= 1'b1;
          avl.avl_read  <= 1'b0;
          avl.avl_write <= 1'b0;
        end
      endcase
    end
  end
endmodule
